muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_div_iter.sv | 58 +++++
 rtl/muldiv_unit.sv | 144 ++++++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M/RV64M multiply/divide execute unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } muldiv_state_e;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;

endpackage

// File: rtl/muldiv_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes; the first step is taken on the start edge,
// so done_o rises XLEN-1 cycles after start and stays for one cycle.
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            done_o
);
    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] quo_q, rem_q, dsr_q;
    logic [XLEN-1:0] quo_src, rem_src, dsr_src, quo_d, rem_d;
    logic [XLEN:0]   shifted, diff;
    logic [CW-1:0]   cnt_q;
    logic            busy;

    assign rem_src = start_i ? '0 : rem_q;
    assign quo_src = start_i ? dividend_i : quo_q;
    assign dsr_src = start_i ? divisor_i : dsr_q;

    // Partial remainder always stays below the divisor, so XLEN bits hold it after restore.
    assign shifted = {rem_src, quo_src[XLEN-1]};
    assign diff    = shifted - {1'b0, dsr_src};
    assign rem_d   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_d   = {quo_src[XLEN-2:0], ~diff[XLEN]};

    assign done_o = (cnt_q == CW'(XLEN));
    assign busy   = (cnt_q != '0) && !done_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (start_i || busy) begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            if (start_i) dsr_q <= divisor_i;
            cnt_q <= start_i ? CW'(1) : cnt_q + CW'(1);
        end else if (done_o) begin
            cnt_q <= '0;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// M-extension execute unit: pipelined multiply, iterative divide, valid/ready on both sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CW       = $clog2(MUL_STAGES + 1);
    localparam int MUL_LAST = (MUL_STAGES > 1) ? MUL_STAGES - 2 : 0;

    muldiv_state_e state_q;
    muldiv_op_e    op_q;
    logic [CW-1:0] cnt_q;
    logic          q_neg_q, r_neg_q;

    logic            accept, is_div, div_signed, div_zero, div_ovf, div_special, div_start, div_done;
    logic [XLEN-1:0] special_res, div_a, div_b, div_quo, div_rem, div_res, mul_res;
    logic [XLEN:0]   mul_a, mul_b;
    logic [2*XLEN-1:0] prod_d;

    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p, input muldiv_op_e op);
        return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept  = valid_i && ready_o && !flush_i;
    assign is_div  = funct3_i[2];

    // Only bits up to 2*XLEN-1 are ever selected, so the extended product is kept at that width.
    assign mul_a  = {(funct3_i[1:0] != 2'b11) & rs1_i[XLEN-1], rs1_i};
    assign mul_b  = {(funct3_i[1:0] == 2'b01) & rs2_i[XLEN-1], rs2_i};
    assign prod_d = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};

    generate
        if (MUL_STAGES == 1) begin : g_mul_comb
            assign mul_res = mul_pick(prod_d, muldiv_op_e'(funct3_i));
        end else begin : g_mul_pipe
            logic [2*XLEN-1:0] pipe_q [MUL_STAGES-1];
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int i = 0; i < MUL_STAGES - 1; i++) pipe_q[i] <= '0;
                end else begin
                    if (accept && !is_div) pipe_q[0] <= prod_d;
                    for (int i = 1; i < MUL_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_res = mul_pick(pipe_q[MUL_STAGES-2], op_q);
        end
    endgenerate

    assign div_signed  = !funct3_i[0];
    assign div_zero    = (rs2_i == '0);
    assign div_ovf     = div_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2_i);
    assign div_special = div_zero || div_ovf;
    assign special_res = div_zero ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : rs1_i);
    assign div_start   = accept && is_div && !div_special;
    assign div_a       = (div_signed && rs1_i[XLEN-1]) ? '0 - rs1_i : rs1_i;
    assign div_b       = (div_signed && rs2_i[XLEN-1]) ? '0 - rs2_i : rs2_i;

    muldiv_div_iter #(.XLEN(XLEN)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .start_i     (div_start),
        .dividend_i  (div_a),
        .divisor_i   (div_b),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .done_o      (div_done)
    );

    assign div_res = (op_q == OP_REM || op_q == OP_REMU) ? (r_neg_q ? '0 - div_rem : div_rem)
                                                         : (q_neg_q ? '0 - div_quo : div_quo);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q  <= muldiv_op_e'(funct3_i);
                    cnt_q <= '0;
                    if (!is_div) begin
                        if (MUL_STAGES == 1) begin
                            state_q  <= S_DONE;
                            valid_o  <= 1'b1;
                            result_o <= mul_res;
                        end else begin
                            state_q <= S_MUL;
                        end
                    end else if (div_special) begin
                        state_q  <= S_DONE;
                        valid_o  <= 1'b1;
                        result_o <= special_res;
                    end else begin
                        state_q <= S_DIV;
                        q_neg_q <= div_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                        r_neg_q <= div_signed && rs1_i[XLEN-1];
                    end
                end
                S_MUL: if (cnt_q == CW'(MUL_LAST)) begin
                    state_q  <= S_DONE;
                    valid_o  <= 1'b1;
                    result_o <= mul_res;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                S_DIV: if (div_done) begin
                    state_q  <= S_DONE;
                    valid_o  <= 1'b1;
                    result_o <= div_res;
                end
                S_DONE: if (ready_i) begin
                    state_q <= S_IDLE;
                    valid_o <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit (32-bit/2-stage and 64-bit/1-stage) against a plain-arithmetic model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        vld, rdy_o, vld_o, rdy_i;
    logic [2:0]  f3;
    logic [31:0] a, b, res_o;
    logic        vld64, rdy64_o, vld64_o, rdy64_i;
    logic [2:0]  f364;
    logic [63:0] a64, b64, res64_o;

    int n_chk = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vld), .ready_o(rdy_o),
        .funct3_i(f3), .rs1_i(a), .rs2_i(b), .valid_o(vld_o), .ready_i(rdy_i), .result_o(res_o)
    );

    muldiv_unit #(.XLEN(64), .MUL_STAGES(1)) dut64 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(vld64), .ready_o(rdy64_o),
        .funct3_i(f364), .rs1_i(a64), .rs2_i(b64), .valid_o(vld64_o), .ready_i(rdy64_i),
        .result_o(res64_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint ux = {32'b0, x};
        longint uy = {32'b0, y};
        int     ix = x;
        int     iy = y;
        logic [63:0] p;
        if (f[2] && y == 0) return f[1] ? x : 32'hFFFFFFFF;
        if (f[2] && !f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return f[1] ? 32'h0 : x;
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: return ix / iy;
            3'd5: return x / y;
            3'd6: return ix % iy;
            default: return x % y;
        endcase
    endfunction

    function automatic int lat32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return 2;
        if (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) return 1;
        return 33;
    endfunction

    function automatic logic [63:0] ref64d(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
        longint sx = x;
        longint sy = y;
        if (y == 0) return f[1] ? x : 64'hFFFFFFFFFFFFFFFF;
        if (!f[0] && x == 64'h8000000000000000 && y == 64'hFFFFFFFFFFFFFFFF) return f[1] ? 64'h0 : x;
        case (f[1:0])
            2'd0: return sx / sy;
            2'd1: return x / y;
            2'd2: return sx % sy;
            default: return x % y;
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on the 32-bit unit; caller sits at a negedge with the unit idle.
    task automatic op32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int bp, input logic [31:0] exp, input int exp_lat);
        int lat;
        logic rdy_seen;
        logic [31:0] held;
        chk("acc_rdy", rdy_o, 1);
        vld = 1; f3 = f; a = x; b = y;
        @(negedge clk);
        vld = 0; a = $urandom; b = $urandom; f3 = 3'($urandom);
        lat = 1; rdy_seen = 0;
        while (!vld_o && lat < 200) begin
            rdy_seen |= rdy_o;
            @(negedge clk);
            lat++;
        end
        rdy_seen |= rdy_o;
        chk($sformatf("lat f%0d", f), lat, exp_lat);
        chk($sformatf("res f%0d %h/%h", f, x, y), res_o, exp);
        held = res_o;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("hold_v", vld_o, 1);
            chk("hold_res", res_o, held);
            chk("hold_rdy", rdy_o, 0);
        end
        chk("busy_rdy", rdy_seen, 0);
        rdy_i = 1;
        @(negedge clk);
        rdy_i = 0;
        chk("drop_v", vld_o, 0);
        chk("rdy_back", rdy_o, 1);
    endtask

    task automatic op64(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int exp_lat);
        int lat;
        chk("acc_rdy64", rdy64_o, 1);
        vld64 = 1; f364 = f; a64 = x; b64 = y;
        @(negedge clk);
        vld64 = 0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        lat = 1;
        while (!vld64_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("lat64 f%0d", f), lat, exp_lat);
        chk($sformatf("res64 f%0d", f), res64_o, exp);
        rdy64_i = 1;
        @(negedge clk);
        rdy64_i = 0;
        chk("drop64", vld64_o, 0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] x, y;
        logic [63:0] xx, yy;
        logic        seen;

        rst = 1; flush = 0; vld = 0; rdy_i = 0; f3 = 0; a = 0; b = 0;
        vld64 = 0; rdy64_i = 0; f364 = 0; a64 = 0; b64 = 0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", rdy_o, 0);
        chk("rst_vld", vld_o, 0);
        chk("rst_res", res_o, 0);
        chk("rst_rdy64", rdy64_o, 0);
        rst = 0;
        @(negedge clk);
        chk("post_rst_rdy", rdy_o, 1);
        chk("post_rst_rdy64", rdy64_o, 1);

        op32(3'd0, 32'hFFFFFFFF, 32'h2, 0, 32'hFFFFFFFE, 2);
        op32(3'd1, 32'hFFFFFFFF, 32'h2, 0, 32'hFFFFFFFF, 2);
        op32(3'd3, 32'hFFFFFFFF, 32'h2, 0, 32'h00000001, 2);
        op32(3'd4, 32'hFFFFFFF9, 32'h2, 0, 32'hFFFFFFFD, 33);
        op32(3'd6, 32'hFFFFFFF9, 32'h2, 0, 32'hFFFFFFFF, 33);
        op32(3'd5, 32'h5, 32'h0, 0, 32'hFFFFFFFF, 1);
        op32(3'd7, 32'h5, 32'h0, 0, 32'h00000005, 1);
        op32(3'd4, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 1);
        op32(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 2);

        // Kill a DIVU partway through its iterations.
        vld = 1; f3 = 3'd5; a = 100; b = 7;
        @(negedge clk);
        vld = 0;
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_rdy", rdy_o, 1);
        chk("flush_vld", vld_o, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= vld_o;
        end
        chk("flush_no_result", seen, 0);
        op32(3'd5, 32'd100, 32'd7, 0, 32'd14, 33);
        op32(3'd7, 32'd100, 32'd7, 0, 32'd2, 33);
        repeat (2) @(negedge clk);
        chk("res_kept", res_o, 32'd2);

        // A flush in the request cycle blocks the accept.
        vld = 1; flush = 1; f3 = 3'd0; a = 3; b = 5;
        @(negedge clk);
        vld = 0; flush = 0;
        chk("fv_rdy", rdy_o, 1);
        @(negedge clk);
        chk("fv_no_vld", vld_o, 0);

        // Reset while a multiply is in flight.
        vld = 1; f3 = 3'd0; a = 3; b = 5;
        @(negedge clk);
        vld = 0;
        chk("mul_busy", rdy_o, 0);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_vld", vld_o, 0);
        chk("mid_rst_res", res_o, 0);
        chk("mid_rst_rdy", rdy_o, 0);
        rst = 0;
        @(negedge clk);
        chk("mid_rst_rdy_back", rdy_o, 1);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_vld", vld_o, 0);

        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom);
            x = pick32();
            y = pick32();
            op32(f, x, y, $urandom_range(0, 2), ref32(f, x, y), lat32(f, x, y));
        end

        op64(3'd3, 64'h8000000000000000, 64'd4, 64'd2, 1);
        op64(3'd0, 64'h8000000000000001, 64'd4, 64'd4, 1);
        op64(3'd4, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
        op64(3'd7, 64'd12345, 64'd0, 64'd12345, 1);
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(4, 7));
            xx = {$urandom, $urandom};
            yy = {$urandom, $urandom} >> $urandom_range(0, 62);
            op64(f, xx, yy, ref64d(f, xx, yy), (yy == 0) ? 1 : 65);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
